// File: rtl/cp0_nested_intc.sv
// ---------------------------------------------------------------------------
// cp0_nested_intc
// Coprocessor-0 interrupt unit for the pipelined MIPS core. It supports
// NUM_IRQ prioritised sources (a higher index means a higher priority), a
// per-source mask, true priority nesting backed by an EPC stack, and a
// vectored handler address.
//
// Ports:
//   clk, rst      single clock; synchronous, active-high reset
//   id_instr      instruction in ID; decoded for mfc0 and eret
//   wb_instr      instruction in WB; decoded for mtc0
//   wb_din        mtc0 write data
//   ex_pc         return address pushed when an interrupt is taken
//   intsrc        raw interrupt request lines (rising-edge sensitive)
//   INT           interrupt take request to the pipeline
//   int_vector    handler address of the source being taken
//   CP0ToReg      ID instruction is mfc0
//   id_dout       mfc0 read data (Status=12, Cause=13, EPC=14, else 0)
//   epc_out       top-of-stack EPC (0 when the stack is empty)
//   eret          ID instruction is eret
//   stack_full    the stack holds STACK_DEPTH entries
// ---------------------------------------------------------------------------
module cp0_nested_intc #(
  parameter int          NUM_IRQ       = 3,
  parameter int          STACK_DEPTH   = 4,
  parameter logic [31:0] VECTOR_BASE   = 32'h0000_0800,
  parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0020
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        id_instr,
  input  logic [31:0]        wb_instr,
  input  logic [31:0]        wb_din,
  input  logic [31:0]        ex_pc,
  input  logic [NUM_IRQ-1:0] intsrc,
  output logic               INT,
  output logic [31:0]        int_vector,
  output logic               CP0ToReg,
  output logic [31:0]        id_dout,
  output logic [31:0]        epc_out,
  output logic               eret,
  output logic               stack_full
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CW = $clog2(STACK_DEPTH + 1);

  // Architectural state
  logic               status_ie;
  logic [NUM_IRQ-1:0] status_im;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] service;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [31:0]        epc_stack [STACK_DEPTH];
  logic [CW-1:0]      depth;

  // Decode
  logic       is_mtc0;
  logic       is_mfc0;
  logic [4:0] wb_rd;
  logic [4:0] id_rd;

  assign is_mtc0  = (wb_instr[31:21] == 11'b010000_00100);
  assign is_mfc0  = (id_instr[31:21] == 11'b010000_00000);
  assign wb_rd    = wb_instr[15:11];
  assign id_rd    = id_instr[15:11];
  assign eret     = (id_instr == 32'h4200_0018);
  assign CP0ToReg = is_mfc0;

  // Priority encoders: the highest set index wins.
  logic          elig_valid;
  logic [IW-1:0] elig_idx;
  logic          cur_valid;
  logic [IW-1:0] cur_idx;

  always_comb begin
    elig_valid = 1'b0;
    elig_idx   = '0;
    cur_valid  = 1'b0;
    cur_idx    = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (pending[i] && status_im[i]) begin
        elig_valid = 1'b1;
        elig_idx   = IW'(i);
      end
      if (service[i]) begin
        cur_valid = 1'b1;
        cur_idx   = IW'(i);
      end
    end
  end

  // Stack status
  logic          stack_empty;
  logic [CW-1:0] top_cnt;

  assign stack_empty = (depth == '0);
  assign stack_full  = (depth == CW'(STACK_DEPTH));
  assign top_cnt     = depth - CW'(1);
  assign epc_out     = stack_empty ? '0 : epc_stack[top_cnt[SW-1:0]];

  // Take decision: only a strictly higher level than the one in service may
  // preempt it, and an eret in ID always wins over a take in the same cycle.
  logic preempt;

  assign preempt    = elig_valid && (!cur_valid || (elig_idx > cur_idx));
  assign INT        = status_ie && preempt && !stack_full && !eret;
  assign int_vector = INT ? (VECTOR_BASE + VECTOR_STRIDE * 32'(elig_idx))
                          : VECTOR_BASE;

  // Per-source update masks
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] take_mask;
  logic [NUM_IRQ-1:0] svc_clr;

  assign rise      = intsrc & ~irq_prev;
  assign take_mask = INT ? (NUM_IRQ'(1) << elig_idx) : '0;
  assign svc_clr   = (eret && !stack_empty && cur_valid) ? (NUM_IRQ'(1) << cur_idx) : '0;

  // Register read view
  logic [31:0] status_word;
  logic [31:0] cause_word;

  always_comb begin
    status_word               = '0;
    status_word[0]            = status_ie;
    status_word[8 +: NUM_IRQ] = status_im;
    cause_word                = '0;
    cause_word[8 +: NUM_IRQ]  = pending;
    cause_word[16 +: NUM_IRQ] = service;
  end

  always_comb begin
    id_dout = '0;
    if (is_mfc0) begin
      case (id_rd)
        5'd12:   id_dout = status_word;
        5'd13:   id_dout = cause_word;
        5'd14:   id_dout = epc_out;
        default: id_dout = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_ie <= 1'b0;
      status_im <= '0;
      pending   <= '0;
      service   <= '0;
      irq_prev  <= '0;
      depth     <= '0;
      for (int unsigned k = 0; k < STACK_DEPTH; k++) begin
        epc_stack[k] <= '0;
      end
    end else begin
      irq_prev <= intsrc;
      // A fresh edge on the source being taken re-arms its pending bit.
      pending  <= (pending & ~take_mask) | rise;
      // take and eret are mutually exclusive because INT is gated by eret.
      service  <= (service | take_mask) & ~svc_clr;

      if (is_mtc0 && (wb_rd == 5'd12)) begin
        status_ie <= wb_din[0];
        status_im <= wb_din[8 +: NUM_IRQ];
      end

      if (INT) begin
        // Overrides any concurrent mtc0 write of IE.
        status_ie                  <= 1'b0;
        epc_stack[depth[SW-1:0]]   <= ex_pc;
        depth                      <= depth + CW'(1);
      end else if (eret && !stack_empty) begin
        depth <= depth - CW'(1);
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wb_instr[20:16], wb_instr[10:0], wb_din, top_cnt};

endmodule

// File: tb/tb_cp0_nested_intc.sv
// ---------------------------------------------------------------------------
// tb_cp0_nested_intc
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model that keeps the nesting stack as a queue of
// {level, return address} entries.
// ---------------------------------------------------------------------------
module tb_cp0_nested_intc;

  localparam int          N  = 3;
  localparam int          D  = 2;
  localparam logic [31:0] VB = 32'h0000_0800;
  localparam logic [31:0] VS = 32'h0000_0020;
  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] ERET = 32'h4200_0018;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  id_instr, wb_instr, wb_din, ex_pc;
  logic [N-1:0] intsrc;
  logic         INT, CP0ToReg, eret, stack_full;
  logic [31:0]  int_vector, id_dout, epc_out;

  always #5 clk = ~clk;

  cp0_nested_intc #(
    .NUM_IRQ(N), .STACK_DEPTH(D), .VECTOR_BASE(VB), .VECTOR_STRIDE(VS)
  ) dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .wb_instr(wb_instr),
    .wb_din(wb_din), .ex_pc(ex_pc), .intsrc(intsrc), .INT(INT),
    .int_vector(int_vector), .CP0ToReg(CP0ToReg), .id_dout(id_dout),
    .epc_out(epc_out), .eret(eret), .stack_full(stack_full)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  typedef struct { int lvl; logic [31:0] pc; } ent_t;
  ent_t         stk[$];
  logic         m_ie;
  logic [N-1:0] m_im, m_pend, m_prev;

  // Model outputs for the current inputs
  logic         e_int, e_cp0, e_eret, e_full;
  logic [31:0]  e_vec, e_dout, e_epc;
  int           e_elig;

  function automatic logic [31:0] MTC0(input logic [4:0] rd);
    return {11'b010000_00100, 5'd0, rd, 11'd0};
  endfunction

  function automatic logic [31:0] MFC0(input logic [4:0] rd);
    return {11'b010000_00000, 5'd0, rd, 11'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    int cur;
    logic [N-1:0] svc;
    cur    = -1;
    svc    = '0;
    e_elig = -1;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_im[i]) e_elig = i;
    foreach (stk[k]) begin
      if (stk[k].lvl > cur) cur = stk[k].lvl;
      svc[stk[k].lvl] = 1'b1;
    end
    e_full = (stk.size() == D);
    e_eret = (id_instr == ERET);
    e_int  = m_ie && (e_elig >= 0) && (e_elig > cur) && !e_full && !e_eret;
    e_vec  = e_int ? VB + VS * 32'(e_elig) : VB;
    e_epc  = (stk.size() == 0) ? 32'h0 : stk[$].pc;
    e_cp0  = (id_instr[31:21] == 11'b010000_00000);
    e_dout = 32'h0;
    if (e_cp0) begin
      case (id_instr[15:11])
        5'd12:   e_dout = (32'(m_im) << 8) | 32'(m_ie);
        5'd13:   e_dout = (32'(m_pend) << 8) | (32'(svc) << 16);
        5'd14:   e_dout = e_epc;
        default: e_dout = 32'h0;
      endcase
    end
  endtask

  task automatic model_step();
    logic [N-1:0] rise;
    if (rst) begin
      m_ie = 1'b0; m_im = '0; m_pend = '0; m_prev = '0;
      stk.delete();
      return;
    end
    model_eval();
    rise = intsrc & ~m_prev;
    if (wb_instr[31:21] == 11'b010000_00100 && wb_instr[15:11] == 5'd12) begin
      m_ie = wb_din[0];
      m_im = wb_din[8 +: N];
    end
    if (e_int) begin
      stk.push_back('{lvl: e_elig, pc: ex_pc});
      m_pend[e_elig] = 1'b0;
      m_ie = 1'b0;
    end
    m_pend = m_pend | rise;
    if (e_eret && stk.size() > 0) void'(stk.pop_back());
    m_prev = intsrc;
  endtask

  // Apply inputs, let them settle away from the edge, compare against model.
  task automatic drive(input logic r, input logic [31:0] idi, input logic [31:0] wbi,
                       input logic [31:0] wbd, input logic [31:0] pc, input logic [N-1:0] src);
    rst = r; id_instr = idi; wb_instr = wbi; wb_din = wbd; ex_pc = pc; intsrc = src;
    #1;
    if (!r) begin
      model_eval();
      chk("INT",        32'(INT),        32'(e_int));
      chk("int_vector", int_vector,      e_vec);
      chk("CP0ToReg",   32'(CP0ToReg),   32'(e_cp0));
      chk("id_dout",    id_dout,         e_dout);
      chk("epc_out",    epc_out,         e_epc);
      chk("eret",       32'(eret),       32'(e_eret));
      chk("stack_full", 32'(stack_full), 32'(e_full));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic step(input logic r, input logic [31:0] idi, input logic [31:0] wbi,
                      input logic [31:0] wbd, input logic [31:0] pc, input logic [N-1:0] src);
    drive(r, idi, wbi, wbd, pc, src);
    tick();
  endtask

  initial begin
    logic [31:0] idi, wbi, wbd;
    logic [N-1:0] src;
    int sel;

    // Reset
    step(1'b1, NOP, NOP, 0, 0, 3'b000);
    step(1'b1, NOP, NOP, 0, 0, 3'b000);
    drive(1'b0, MFC0(5'd5), NOP, 0, 0, 3'b000);
    chk("rst_INT", 32'(INT), 32'h0);
    chk("rst_vec", int_vector, 32'h0000_0800);
    chk("rst_epc", epc_out, 32'h0);
    chk("rst_full", 32'(stack_full), 32'h0);
    chk("rst_dout", id_dout, 32'h0);
    tick();

    // Single take of source 2
    step(1'b0, NOP, MTC0(5'd12), 32'h0000_0701, 0, 3'b000);
    step(1'b0, NOP, NOP, 0, 0, 3'b100);
    drive(1'b0, MFC0(5'd13), NOP, 0, 32'h0000_1000, 3'b100);
    chk("t1_pend", 32'(id_dout[10:8]), 32'h4);
    chk("t1_INT", 32'(INT), 32'h1);
    chk("t1_vec", int_vector, 32'h0000_0840);
    tick();
    drive(1'b0, MFC0(5'd13), NOP, 0, 0, 3'b100);
    chk("t1_svc", 32'(id_dout[18:16]), 32'h4);
    chk("t1_epc", epc_out, 32'h0000_1000);
    tick();
    drive(1'b0, MFC0(5'd12), NOP, 0, 0, 3'b100);
    chk("t1_ie", 32'(id_dout[0]), 32'h0);
    tick();

    // Lower source during level-2 service, then eret
    step(1'b0, NOP, MTC0(5'd12), 32'h0000_0701, 0, 3'b100);
    step(1'b0, NOP, NOP, 0, 0, 3'b001);
    drive(1'b0, MFC0(5'd13), NOP, 0, 0, 3'b001);
    chk("t2_pend", 32'(id_dout[10:8]), 32'h1);
    chk("t2_noINT", 32'(INT), 32'h0);
    tick();
    step(1'b0, ERET, NOP, 0, 0, 3'b001);
    drive(1'b0, MFC0(5'd13), NOP, 0, 32'h0000_2000, 3'b001);
    chk("t2_svc", 32'(id_dout[18:16]), 32'h0);
    chk("t2_INT", 32'(INT), 32'h1);
    chk("t2_vec", int_vector, 32'h0000_0800);
    tick();
    step(1'b0, ERET, NOP, 0, 0, 3'b001);

    // Mask
    step(1'b0, NOP, MTC0(5'd12), 32'h0000_0201, 0, 3'b000);
    step(1'b0, NOP, NOP, 0, 0, 3'b001);
    drive(1'b0, MFC0(5'd13), NOP, 0, 0, 3'b001);
    chk("t3_pend", 32'(id_dout[10:8]), 32'h1);
    chk("t3_masked", 32'(INT), 32'h0);
    tick();
    step(1'b0, NOP, MTC0(5'd12), 32'h0000_0301, 0, 3'b001);
    drive(1'b0, NOP, NOP, 0, 32'h0000_3000, 3'b001);
    chk("t3_INT", 32'(INT), 32'h1);
    tick();
    step(1'b0, ERET, NOP, 0, 0, 3'b001);

    // Nesting to a full stack
    step(1'b0, NOP, MTC0(5'd12), 32'h0000_0701, 0, 3'b000);
    step(1'b0, NOP, NOP, 0, 0, 3'b001);
    drive(1'b0, NOP, NOP, 0, 32'h0000_A000, 3'b001);
    chk("t4_take0", 32'(INT), 32'h1);
    tick();
    step(1'b0, NOP, MTC0(5'd12), 32'h0000_0701, 0, 3'b001);
    step(1'b0, NOP, NOP, 0, 0, 3'b011);
    drive(1'b0, NOP, NOP, 0, 32'h0000_B000, 3'b011);
    chk("t4_vec1", int_vector, 32'h0000_0820);
    tick();
    step(1'b0, NOP, MTC0(5'd12), 32'h0000_0701, 0, 3'b011);
    step(1'b0, NOP, NOP, 0, 0, 3'b111);
    drive(1'b0, NOP, NOP, 0, 0, 3'b111);
    chk("t4_full", 32'(stack_full), 32'h1);
    chk("t4_blocked", 32'(INT), 32'h0);
    tick();
    step(1'b0, ERET, NOP, 0, 0, 3'b111);
    drive(1'b0, NOP, NOP, 0, 32'h0000_C000, 3'b111);
    chk("t4_epcA", epc_out, 32'h0000_A000);
    chk("t4_notfull", 32'(stack_full), 32'h0);
    chk("t4_INT2", 32'(INT), 32'h1);
    chk("t4_vec2", int_vector, 32'h0000_0840);
    tick();
    step(1'b0, ERET, NOP, 0, 0, 3'b000);
    step(1'b0, ERET, NOP, 0, 0, 3'b000);

    // eret on empty stack
    drive(1'b0, ERET, NOP, 0, 0, 3'b000);
    chk("t5_eret", 32'(eret), 32'h1);
    chk("t5_epc", epc_out, 32'h0);
    tick();
    drive(1'b0, MFC0(5'd13), NOP, 0, 0, 3'b000);
    chk("t5_cause", id_dout, 32'h0);
    tick();
    drive(1'b0, MFC0(5'd14), NOP, 0, 0, 3'b000);
    chk("t5_cp0", 32'(CP0ToReg), 32'h1);
    chk("t5_dout", id_dout, 32'h0);
    tick();

    // eret with an eligible interrupt in the same cycle
    step(1'b0, NOP, MTC0(5'd12), 32'h0000_0701, 0, 3'b000);
    step(1'b0, NOP, NOP, 0, 0, 3'b001);
    step(1'b0, NOP, NOP, 0, 32'h0000_D000, 3'b001);
    step(1'b0, NOP, MTC0(5'd12), 32'h0000_0701, 0, 3'b001);
    step(1'b0, NOP, NOP, 0, 0, 3'b011);
    drive(1'b0, ERET, NOP, 0, 0, 3'b011);
    chk("t6_held", 32'(INT), 32'h0);
    tick();
    drive(1'b0, NOP, NOP, 0, 32'h0000_E000, 3'b011);
    chk("t6_INT", 32'(INT), 32'h1);
    chk("t6_vec", int_vector, 32'h0000_0820);
    tick();

    // Reset in mid-service
    step(1'b1, NOP, NOP, 0, 0, 3'b000);
    drive(1'b0, MFC0(5'd13), NOP, 0, 0, 3'b000);
    chk("t7_INT", 32'(INT), 32'h0);
    chk("t7_vec", int_vector, 32'h0000_0800);
    chk("t7_epc", epc_out, 32'h0);
    chk("t7_full", 32'(stack_full), 32'h0);
    chk("t7_cause", id_dout, 32'h0);
    tick();

    // Randomized traffic
    src = '0;
    for (int c = 0; c < 3000; c++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        3:       idi = ERET;
        4:       idi = MFC0(5'd12);
        5:       idi = MFC0(5'd13);
        6:       idi = MFC0(5'd14);
        7:       idi = MFC0(5'($urandom));
        default: idi = NOP;
      endcase
      sel = int'($urandom_range(0, 7));
      wbd = $urandom;
      if (sel == 6) begin
        wbi = MTC0(5'd12);
        if ($urandom_range(0, 3) != 0) wbd[0] = 1'b1;
      end else if (sel == 7) begin
        wbi = MTC0(5'($urandom));
      end else begin
        wbi = NOP;
      end
      if ($urandom_range(0, 2) == 0) src = N'($urandom);
      step(($urandom_range(0, 299) == 0), idi, wbi, wbd, $urandom, src);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_nested_intc.md
# cp0_nested_intc

Parametrised coprocessor-0 interrupt unit for the pipelined MIPS core, generalising the fixed three-source CP0. Supports NUM_IRQ prioritised sources with per-source masks, true priority nesting backed by an EPC stack of configurable depth, and a vectored handler address. Sits beside the ID/WB stages: decodes mfc0/eret from ID, commits mtc0 from WB, and samples ex_pc when an interrupt is taken.

## Interface
- NUM_IRQ, 3, number of interrupt sources (1..8); higher index = higher priority
- STACK_DEPTH, 4, EPC/service-level stack entries (1..8)
- VECTOR_BASE, 32'h0000_0800, handler address of source 0
- VECTOR_STRIDE, 32'h0000_0020, address distance between consecutive source handlers
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_instr  in  32  instruction in ID (mfc0 / eret decode)
- wb_instr  in  32  instruction in WB (mtc0 decode)
- wb_din  in  32  mtc0 write data
- ex_pc  in  32  return address saved when an interrupt is taken
- intsrc  in  NUM_IRQ  raw interrupt request lines
- INT  out  1  interrupt take request to the pipeline
- int_vector  out  32  handler address, valid while INT=1
- CP0ToReg  out  1  ID instruction is mfc0
- id_dout  out  32  mfc0 read data
- epc_out  out  32  top-of-stack EPC
- eret  out  1  ID instruction is eret
- stack_full  out  1  stack holds STACK_DEPTH entries

## Operation
- Decode: mtc0 = wb_instr[31:21]==11'b010000_00100, rd=wb_instr[15:11]; mfc0 = id_instr[31:21]==11'b010000_00000, rd=id_instr[15:11]; eret = id_instr==32'h4200_0018. CP0ToReg/eret combinational.
- Registers: Status(12): bit0 IE, bits[8+:NUM_IRQ] IM, other bits read 0, writable via mtc0. Cause(13), read-only: [8+:NUM_IRQ] pending, [16+:NUM_IRQ] in-service. EPC(14): top of stack, read-only. mfc0 of any other rd returns 0.
- Pending: bit i set on rising edge of intsrc[i] (registered previous value); cleared when source i is taken. New edge on the take cycle of the same source keeps the bit set.
- Eligible level = highest i with pending[i]&IM[i]; current level = highest in-service bit (−1 if none).
- INT = IE & eligible exists & eligible > current & !stack_full & !eret.
- On INT cycle: push ex_pc, set service[eligible], clear pending[eligible], clear IE. int_vector = VECTOR_BASE + eligible*VECTOR_STRIDE.
- On eret with non-empty stack: pop, clear highest in-service bit. eret on empty stack: no state change.
- IE re-enabled only by mtc0 to reg 12.

## Timing
- Reset: Status=0, pending=0, service=0, stack empty, edge register=0; INT=0, int_vector=VECTOR_BASE, epc_out=0, stack_full=0, id_dout=0 for non-mfc0.
- intsrc edge at clock k -> pending visible (Cause, INT) from cycle k+1; INT combinational from registered state.
- INT is effectively one cycle: IE cleared at the take edge.
- Simultaneous mtc0 Status and take: IM from wb_din written, IE forced 0.
- Simultaneous eret and eligible interrupt: eret processed, INT held 0 that cycle; take may occur next cycle.
- epc_out = 0 when stack empty; updates the cycle after push/pop.
- mfc0 Cause/EPC in the same cycle as a state change returns pre-edge value.
- Reset mid-service clears stack and all service bits at that edge.

## Test plan
- Reset, mtc0 Status=32'h0000_0701, pulse intsrc=3'b100 -> next cycle Cause[10:8]=100, INT=1, int_vector=32'h0000_0840; after edge Cause[18:16]=100, epc_out=ex_pc, IE=0.
- During level-2 service, IE re-enabled, pulse intsrc=3'b001 -> pending=001, INT stays 0; eret -> service=000, INT=1 for source 0, int_vector=32'h0000_0800.
- Mask test: Status=32'h0000_0201 (IM=010), edge on source 0 -> pending=001, INT=0; write IM=011 -> INT next cycle.
- Nesting with STACK_DEPTH=2: take 0 (ex_pc=A), enable, take 1 (B), enable, edge on 2 -> stack_full=1, INT=0; eret -> epc_out=A, stack_full=0, INT for source 2.
- eret on empty stack -> eret=1, epc_out=0, Cause unchanged; mfc0 rd=14 -> CP0ToReg=1, id_dout=0.
- Eret and edge same cycle: INT=0 that cycle, INT=1 next cycle; reset asserted mid-service -> all outputs at reset values next cycle.
